// File: rtl/weight_fifo_in_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : weight_fifo_in_ctrl_if
// Brief    : Handshake/bus bundle between the weight FIFO write controller,
//            the weight SRAM read port and the FIFO bank.
// Revision : 1.0 - initial release
// ============================================================================
interface weight_fifo_in_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 32
);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);

    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  fifo_pop;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [FIFO_WIDTH-1:0] fifo_wen;
    logic [c_OCC_W-1:0]    occupancy;
`ifdef WFIFO_IN_ERR_CHECK_EN
    logic                  err;
`endif

    modport slave (
        input  start, base_addr, fifo_pop,
`ifdef WFIFO_IN_ERR_CHECK_EN
        output err,
`endif
        output busy, done, rd_en, rd_addr, fifo_wen, occupancy
    );

    modport master (
        output start, base_addr, fifo_pop,
`ifdef WFIFO_IN_ERR_CHECK_EN
        input  err,
`endif
        input  busy, done, rd_en, rd_addr, fifo_wen, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/weight_fifo_in_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_fifo_in_ctrl
// Brief    : Streams SYS_ROW weight rows from SRAM into the column FIFO bank,
//            credit-limited by FIFO occupancy plus reads still in flight.
//            Optional WFIFO_IN_ERR_CHECK_EN adds a sticky err flag and checks.
// Revision : 1.0 - initial release
// ============================================================================
module weight_fifo_in_ctrl #(
    parameter int SYS_ROW      = 16,
    parameter int FIFO_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    weight_fifo_in_ctrl_if.slave  bus
);
    localparam int c_CNT_W = $clog2(SYS_ROW + 1);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_INF_W = $clog2(READ_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SYS_ROW - 1);
    localparam logic [31:0]        c_DEPTH = 32'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [c_CNT_W-1:0]      r_issue_cnt;
    logic [c_CNT_W-1:0]      r_wr_cnt;
    logic [READ_LATENCY-1:0] r_vld;
    logic [c_OCC_W-1:0]      r_occ;
    logic [c_INF_W-1:0]      w_inflight;
    logic                    w_credit;
    logic                    w_rd_en;
    logic                    w_done;
    logic                    w_push;
    logic                    w_pop;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + c_INF_W'(r_vld[i]);
        end
    end

    // Registered occupancy only: a pop frees credit one cycle later.
    assign w_credit = (32'(r_occ) + 32'(w_inflight)) < c_DEPTH;
    assign w_push   = r_vld[READ_LATENCY-1];
    assign w_pop    = bus.fifo_pop && (r_occ != '0);

    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_next_state = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_credit) begin
                    w_rd_en = 1'b1;
                    if (r_issue_cnt == c_LAST) begin
                        w_next_state = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                if (w_push && (r_wr_cnt == c_LAST)) begin
                    w_done       = 1'b1;
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_wr_cnt    <= '0;
            r_occ       <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_IDLE) && bus.start) begin
                r_base      <= bus.base_addr;
                r_issue_cnt <= '0;
                r_wr_cnt    <= '0;
            end else begin
                if (w_rd_en) begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                if (w_push) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Valid pipeline mirrors the SRAM read latency; its tail is the push.
    generate
        if (READ_LATENCY == 1) begin : g_vld_single
            always_ff @(posedge clk) begin
                if (rst) r_vld <= '0;
                else     r_vld <= w_rd_en;
            end
        end else begin : g_vld_shift
            always_ff @(posedge clk) begin
                if (rst) r_vld <= '0;
                else     r_vld <= {r_vld[READ_LATENCY-2:0], w_rd_en};
            end
        end
    endgenerate

    assign bus.busy      = (r_state != c_IDLE);
    assign bus.done      = w_done;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr   = r_base + ADDR_WIDTH'(r_issue_cnt);
    assign bus.fifo_wen  = {FIFO_WIDTH{w_push}};
    assign bus.occupancy = r_occ;

`ifdef WFIFO_IN_ERR_CHECK_EN
    localparam logic [c_CNT_W-1:0] c_ROWS = c_CNT_W'(SYS_ROW);
    localparam logic [c_OCC_W-1:0] c_FULL = c_OCC_W'(FIFO_DEPTH);
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((bus.fifo_pop && (r_occ == '0)) ||
                     (w_push && (r_occ == c_FULL) && !bus.fifo_pop)) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_wr_cnt <= c_ROWS);
        end
    end

    assign bus.err = r_err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_weight_fifo_in_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_fifo_in_ctrl
// Brief    : Directed self-checking bench; one DUT with the default 32-deep
//            bank and one with a 4-deep bank for credit stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_fifo_in_ctrl;
    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    weight_fifo_in_ctrl_if #(.ADDR_WIDTH(12), .FIFO_WIDTH(16), .FIFO_DEPTH(32)) ifa ();
    weight_fifo_in_ctrl_if #(.ADDR_WIDTH(12), .FIFO_WIDTH(16), .FIFO_DEPTH(4))  ifb ();

    weight_fifo_in_ctrl #(
        .SYS_ROW(16), .FIFO_WIDTH(16), .FIFO_DEPTH(32), .ADDR_WIDTH(12), .READ_LATENCY(2)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    weight_fifo_in_ctrl #(
        .SYS_ROW(16), .FIFO_WIDTH(16), .FIFO_DEPTH(4), .ADDR_WIDTH(12), .READ_LATENCY(2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wen_cnt;
        int done_cnt;
        int rd_cnt;
        int bad_cnt;

        rst = 1'b1;
        ifa.start = 1'b0; ifa.base_addr = '0; ifa.fifo_pop = 1'b0;
        ifb.start = 1'b0; ifb.base_addr = '0; ifb.fifo_pop = 1'b0;
        repeat (3) tick();

        check("rst_busy",  ifa.busy,      0);
        check("rst_done",  ifa.done,      0);
        check("rst_rd_en", ifa.rd_en,     0);
        check("rst_wen",   ifa.fifo_wen,  0);
        check("rst_addr",  ifa.rd_addr,   0);
        check("rst_occ",   ifa.occupancy, 0);
`ifdef WFIFO_IN_ERR_CHECK_EN
        check("rst_err",   ifa.err,       0);
`endif
        rst = 1'b0;
        tick();

        // Unstalled tile from 0x010, no pops
        ifa.base_addr = 12'h010;
        ifa.start     = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) ifa.start = 1'b0;
            check("t1_rd_en", ifa.rd_en,    (k <= 16) ? 64'd1 : 64'd0);
            if (k <= 16) check("t1_rd_addr", ifa.rd_addr, 64'(12'h010 + k - 1));
            check("t1_wen",   ifa.fifo_wen, (k >= 3 && k <= 18) ? 64'hFFFF : 64'h0);
            check("t1_done",  ifa.done,     (k == 18) ? 64'd1 : 64'd0);
            check("t1_busy",  ifa.busy,     (k <= 18) ? 64'd1 : 64'd0);
        end
        check("t1_occ", ifa.occupancy, 16);

        // Drain to occupancy 3
        ifa.fifo_pop = 1'b1;
        repeat (13) tick();
        ifa.fifo_pop = 1'b0;
        check("pop_occ", ifa.occupancy, 3);

        // Wrapping address, push+pop in lockstep, ignored start while busy
        ifa.base_addr = 12'hFFE;
        ifa.start     = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            ifa.start    = (k == 5) || (k == 19);
            ifa.fifo_pop = (k >= 3 && k <= 18);
            if (k <= 16) check("t2_rd_addr", ifa.rd_addr, 64'((12'hFFE + k - 1) & 12'hFFF));
            check("t2_occ",  ifa.occupancy, 3);
            check("t2_done", ifa.done, (k == 18) ? 64'd1 : 64'd0);
            check("t2_busy", ifa.busy, (k <= 18) ? 64'd1 : 64'd0);
            if (k == 19) ifa.base_addr = 12'h100;
        end
`ifdef WFIFO_IN_ERR_CHECK_EN
        check("t2_err", ifa.err, 0);
`endif

        // Back-to-back tile accepted in the cycle after done
        wen_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 1) begin
                ifa.start = 1'b0;
                check("b2b_busy", ifa.busy, 1);
                check("b2b_addr0", ifa.rd_addr, 12'h100);
            end
            if (ifa.fifo_wen == 16'hFFFF) wen_cnt++;
            if (ifa.done) begin
                done_cnt++;
                check("b2b_done_cycle", k, 18);
            end
        end
        check("b2b_pushes", wen_cnt,  16);
        check("b2b_dones",  done_cnt, 1);
        check("b2b_occ",    ifa.occupancy, 19);

        // Reset in the middle of a load
        ifa.base_addr = 12'h200;
        ifa.start     = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) ifa.start = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy",  ifa.busy,      0);
        check("mid_rst_done",  ifa.done,      0);
        check("mid_rst_rd_en", ifa.rd_en,     0);
        check("mid_rst_wen",   ifa.fifo_wen,  0);
        check("mid_rst_addr",  ifa.rd_addr,   0);
        check("mid_rst_occ",   ifa.occupancy, 0);
        bad_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ifa.fifo_wen != 16'h0 || ifa.done || ifa.rd_en || ifa.busy) bad_cnt++;
        end
        check("post_rst_quiet", bad_cnt, 0);

`ifdef WFIFO_IN_ERR_CHECK_EN
        check("err_pre", ifa.err, 0);
        ifa.fifo_pop = 1'b1;
        tick();
        ifa.fifo_pop = 1'b0;
        check("err_set", ifa.err, 1);
        check("err_occ", ifa.occupancy, 0);
        repeat (3) tick();
        check("err_sticky", ifa.err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_clr", ifa.err, 0);
`endif

        // Credit stall on a 4-deep bank
        ifb.base_addr = 12'h000;
        ifb.start     = 1'b1;
        rd_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) ifb.start = 1'b0;
            if (ifb.rd_en) rd_cnt++;
            if (k == 5) check("b_stall_k5", ifb.rd_en, 0);
        end
        check("b_rd_cnt", rd_cnt, 4);
        check("b_occ_full", ifb.occupancy, 4);
        check("b_stall_k10", ifb.rd_en, 0);
        ifb.fifo_pop = 1'b1;
        tick();
        ifb.fifo_pop = 1'b0;
        check("b_resume", ifb.rd_en, 1);
        check("b_resume_addr", ifb.rd_addr, 4);
        check("b_occ_after_pop", ifb.occupancy, 3);
        tick();
        check("b_single_issue", ifb.rd_en, 0);
        tick();
        check("b_push", ifb.fifo_wen, 16'hFFFF);
        tick();
        check("b_occ_refull", ifb.occupancy, 4);
        check("b_stall_again", ifb.rd_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
